// File: rtl/water_tiler_if.sv
// Bundles the pixel stream, animation control, pattern write port and
// outputs of water_tiler. clk and rst stay outside as plain ports.
// Modports:
//   master : drives pixel, control and write inputs; observes outputs.
//   slave  : the tiler side.
interface water_tiler_if #(
  parameter int COORD_W  = 11,
  parameter int PAT_LOG2 = 5
);
  localparam int PAT_N = 1 << PAT_LOG2;

  // Pixel stream in
  logic                pix_valid_in;
  logic [COORD_W-1:0]  px;
  logic [COORD_W-1:0]  py;
  logic [COORD_W-1:0]  ox;
  logic [COORD_W-1:0]  oy;

  // Animation control
  logic                frame_start;
  logic                scroll_en;
  logic [1:0]          mode;

  // Pattern row write port
  logic                wr_en;
  logic [PAT_LOG2-1:0] wr_addr;
  logic [PAT_N-1:0]    wr_data;

  // Results
  logic                water_color;
  logic                in_obj_out;
  logic                pix_valid_out;

  modport master (
    output pix_valid_in, px, py, ox, oy,
    output frame_start, scroll_en, mode,
    output wr_en, wr_addr, wr_data,
    input  water_color, in_obj_out, pix_valid_out
  );

  modport slave (
    input  pix_valid_in, px, py, ox, oy,
    input  frame_start, scroll_en, mode,
    input  wr_en, wr_addr, wr_data,
    output water_color, in_obj_out, pix_valid_out
  );
endinterface

// File: rtl/water_tiler.sv
// Purpose: maps each screen pixel to a bit of a scrolling, tiled PAT_N x PAT_N pattern.
// Latency: fixed 2 cycles from pix_valid_in to pix_valid_out.
// Backpressure: none; one pixel accepted every cycle, no stall.
// Ports:
//   clk  : single clock.
//   rst  : asynchronous active-low reset.
//   bus  : water_tiler_if.slave (pixel in, origin, animation control,
//          pattern write port, water_color/in_obj_out/pix_valid_out).
module water_tiler #(
  parameter int COORD_W    = 11,
  parameter int PAT_LOG2   = 5,
  parameter int SCALE_LOG2 = 2,
  parameter int OBJ_W      = 128,
  parameter int OBJ_H      = 128,
  parameter int ANIM_DIV   = 4
) (
  input  logic          clk,
  input  logic          rst,
  water_tiler_if.slave  bus
);
  localparam int PAT_N = 1 << PAT_LOG2;
  localparam int CNT_W = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ANIM_DIV - 1);

  // ---------------------------------------------------------------------
  // Animation state
  // ---------------------------------------------------------------------
  logic [CNT_W-1:0]    frame_cnt_q, frame_cnt_d;
  logic [PAT_LOG2-1:0] scroll_x_q,  scroll_x_d;
  logic [PAT_LOG2-1:0] scroll_y_q,  scroll_y_d;

  always_comb begin
    frame_cnt_d = frame_cnt_q;
    scroll_x_d  = scroll_x_q;
    scroll_y_d  = scroll_y_q;
    if (bus.frame_start && bus.scroll_en) begin
      if (frame_cnt_q == CNT_LAST) begin
        frame_cnt_d = '0;
        // A disabled axis simply holds; mode changes never clear offsets.
        if (bus.mode[0]) scroll_x_d = scroll_x_q + PAT_LOG2'(1);
        if (bus.mode[1]) scroll_y_d = scroll_y_q + PAT_LOG2'(1);
      end else begin
        frame_cnt_d = frame_cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      frame_cnt_q <= '0;
      scroll_x_q  <= '0;
      scroll_y_q  <= '0;
    end else begin
      frame_cnt_q <= frame_cnt_d;
      scroll_x_q  <= scroll_x_d;
      scroll_y_q  <= scroll_y_d;
    end
  end

  // ---------------------------------------------------------------------
  // Stage 1: region test and pattern coordinates
  // ---------------------------------------------------------------------
  // Compares run one bit wider so ox+OBJ_W near the coordinate maximum
  // does not wrap and falsely reject pixels.
  logic [COORD_W:0]    px_e, py_e, ox_e, oy_e, x_end, y_end;
  logic [COORD_W-1:0]  rel_x, rel_y, cell_x, cell_y;
  logic                inobj_d;
  logic [PAT_LOG2-1:0] row_d, col_d;

  assign px_e  = {1'b0, bus.px};
  assign py_e  = {1'b0, bus.py};
  assign ox_e  = {1'b0, bus.ox};
  assign oy_e  = {1'b0, bus.oy};
  assign x_end = ox_e + (COORD_W+1)'(OBJ_W);
  assign y_end = oy_e + (COORD_W+1)'(OBJ_H);

  assign rel_x  = bus.px - bus.ox;
  assign rel_y  = bus.py - bus.oy;
  assign cell_x = rel_x >> SCALE_LOG2;
  assign cell_y = rel_y >> SCALE_LOG2;

  always_comb begin
    inobj_d = (px_e >= ox_e) && (px_e < x_end) &&
              (py_e >= oy_e) && (py_e < y_end);
    row_d   = '0;
    col_d   = '0;
    // Truncating the sum to PAT_LOG2 bits gives the mod-PAT_N tiling.
    if (inobj_d) begin
      col_d = cell_x[PAT_LOG2-1:0] + scroll_x_q;
      row_d = cell_y[PAT_LOG2-1:0] + scroll_y_q;
    end
  end

  logic                s1_valid_q;
  logic                s1_inobj_q;
  logic [PAT_LOG2-1:0] s1_row_q;
  logic [PAT_LOG2-1:0] s1_col_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_valid_q <= 1'b0;
      s1_inobj_q <= 1'b0;
      s1_row_q   <= '0;
      s1_col_q   <= '0;
    end else begin
      s1_valid_q <= bus.pix_valid_in;
      s1_inobj_q <= inobj_d;
      s1_row_q   <= row_d;
      s1_col_q   <= col_d;
    end
  end

  // ---------------------------------------------------------------------
  // Pattern store: bit c of row word r is screen column c (bit 0 leftmost)
  // ---------------------------------------------------------------------
  logic [PAT_N-1:0] pat_q [PAT_N];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int r = 0; r < PAT_N; r++) pat_q[r] <= '0;
    end else if (bus.wr_en) begin
      pat_q[bus.wr_addr] <= bus.wr_data;
    end
  end

  // ---------------------------------------------------------------------
  // Stage 2: pattern lookup and output registers
  // ---------------------------------------------------------------------
  // The read samples pat_q before the edge, so a same-cycle write to the
  // row being read returns the old word.
  logic pat_bit;
  logic water_color_q, in_obj_q, pix_valid_q;

  assign pat_bit = pat_q[s1_row_q][s1_col_q];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      water_color_q <= 1'b0;
      in_obj_q      <= 1'b0;
      pix_valid_q   <= 1'b0;
    end else begin
      water_color_q <= s1_valid_q & s1_inobj_q & pat_bit;
      in_obj_q      <= s1_valid_q & s1_inobj_q;
      pix_valid_q   <= s1_valid_q;
    end
  end

  assign bus.water_color   = water_color_q;
  assign bus.in_obj_out    = in_obj_q;
  assign bus.pix_valid_out = pix_valid_q;

endmodule

// File: tb/tb_water_tiler.sv
module tb_water_tiler;
  logic clk;
  logic rst_n;
  int   tests_run;
  int   tests_failed;
  logic [2:0] got;

  water_tiler_if #(.COORD_W(11), .PAT_LOG2(5)) bus ();

  water_tiler #(
    .COORD_W(11), .PAT_LOG2(5), .SCALE_LOG2(2),
    .OBJ_W(128), .OBJ_H(128), .ANIM_DIV(4)
  ) dut (
    .clk (clk),
    .rst (rst_n),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic idle_inputs();
    bus.pix_valid_in = 1'b0;
    bus.px = '0; bus.py = '0; bus.ox = '0; bus.oy = '0;
    bus.frame_start = 1'b0;
    bus.scroll_en = 1'b0;
    bus.mode = 2'b00;
    bus.wr_en = 1'b0;
    bus.wr_addr = '0;
    bus.wr_data = '0;
  endtask

  task automatic pix(input int x, input int y, input int o_x, input int o_y);
    bus.pix_valid_in = 1'b1;
    bus.px = 11'(x);
    bus.py = 11'(y);
    bus.ox = 11'(o_x);
    bus.oy = 11'(o_y);
  endtask

  // Applies one pixel and returns at the negedge where its result is visible.
  task automatic send(input int x, input int y, input int o_x, input int o_y);
    @(negedge clk);
    pix(x, y, o_x, o_y);
    @(negedge clk);
    bus.pix_valid_in = 1'b0;
    @(negedge clk);
    got = {bus.pix_valid_out, bus.in_obj_out, bus.water_color};
  endtask

  task automatic write_row(input int addr, input logic [31:0] data);
    @(negedge clk);
    bus.wr_en = 1'b1;
    bus.wr_addr = 5'(addr);
    bus.wr_data = data;
    @(negedge clk);
    bus.wr_en = 1'b0;
  endtask

  task automatic pulses(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      bus.frame_start = 1'b1;
      @(negedge clk);
      bus.frame_start = 1'b0;
    end
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    got = {bus.pix_valid_out, bus.in_obj_out, bus.water_color};
    tests_run++;
    if (got !== 3'b000) begin
      tests_failed++;
      $display("FAIL reset_outputs: got %b want 000", got);
    end
    rst_n = 1'b1;
    @(negedge clk);
    got = {bus.pix_valid_out, bus.in_obj_out, bus.water_color};
    tests_run++;
    if (got !== 3'b000) begin
      tests_failed++;
      $display("FAIL reset_release_idle: got %b want 000", got);
    end
  endtask

  task automatic test_basic();
    @(negedge clk);
    pix(10, 10, 0, 0);
    @(negedge clk);
    bus.pix_valid_in = 1'b0;
    tests_run++;
    if (bus.pix_valid_out !== 1'b0) begin
      tests_failed++;
      $display("FAIL basic_latency1: got %b want 0", bus.pix_valid_out);
    end
    @(negedge clk);
    got = {bus.pix_valid_out, bus.in_obj_out, bus.water_color};
    tests_run++;
    if (got !== 3'b110) begin
      tests_failed++;
      $display("FAIL basic_latency2: got %b want 110", got);
    end
  endtask

  task automatic test_pattern();
    write_row(2, 32'h0000_0004);
    send(9, 8, 0, 0);
    tests_run++;
    if (got !== 3'b111) begin
      tests_failed++;
      $display("FAIL pattern_hit: got %b want 111", got);
    end
    send(12, 8, 0, 0);
    tests_run++;
    if (got !== 3'b110) begin
      tests_failed++;
      $display("FAIL pattern_miss: got %b want 110", got);
    end
    send(109, 8, 100, 0);
    tests_run++;
    if (got !== 3'b111) begin
      tests_failed++;
      $display("FAIL pattern_origin: got %b want 111", got);
    end
  endtask

  task automatic test_edges();
    int vx[7]  = '{99, 227, 228, 2047, 10, 10, 10};
    int vy[7]  = '{10, 10, 10, 10, 2047, 127, 128};
    int vox[7] = '{100, 100, 100, 2000, 0, 0, 0};
    int voy[7] = '{0, 0, 0, 0, 2000, 0, 0};
    logic [2:0] exp_v[7] = '{3'b100, 3'b110, 3'b100, 3'b110, 3'b110, 3'b110, 3'b100};
    for (int i = 0; i < 7; i++) begin
      send(vx[i], vy[i], vox[i], voy[i]);
      tests_run++;
      if (got !== exp_v[i]) begin
        tests_failed++;
        $display("FAIL edge_%0d (px=%0d py=%0d ox=%0d oy=%0d): got %b want %b",
                 i, vx[i], vy[i], vox[i], voy[i], got, exp_v[i]);
      end
    end
  endtask

  task automatic test_same_cycle_write();
    @(negedge clk);
    pix(9, 8, 0, 0);
    @(negedge clk);
    pix(9, 8, 0, 0);
    bus.wr_en = 1'b1;
    bus.wr_addr = 5'd2;
    bus.wr_data = 32'h0;
    @(negedge clk);
    bus.pix_valid_in = 1'b0;
    bus.wr_en = 1'b0;
    got = {bus.pix_valid_out, bus.in_obj_out, bus.water_color};
    tests_run++;
    if (got !== 3'b111) begin
      tests_failed++;
      $display("FAIL same_cycle_old: got %b want 111", got);
    end
    @(negedge clk);
    got = {bus.pix_valid_out, bus.in_obj_out, bus.water_color};
    tests_run++;
    if (got !== 3'b110) begin
      tests_failed++;
      $display("FAIL same_cycle_new: got %b want 110", got);
    end
    write_row(2, 32'h0000_0004);
  endtask

  task automatic test_scroll();
    @(negedge clk);
    bus.scroll_en = 1'b1;
    bus.mode = 2'b01;
    pulses(3);
    // 4th pulse coincides with pixel A: A must still see scroll_x=0.
    @(negedge clk);
    bus.frame_start = 1'b1;
    pix(8, 8, 0, 0);
    @(negedge clk);
    bus.frame_start = 1'b0;
    pix(8, 8, 0, 0);
    @(negedge clk);
    bus.pix_valid_in = 1'b0;
    got = {bus.pix_valid_out, bus.in_obj_out, bus.water_color};
    tests_run++;
    if (got !== 3'b111) begin
      tests_failed++;
      $display("FAIL scroll_same_edge_old: got %b want 111", got);
    end
    @(negedge clk);
    got = {bus.pix_valid_out, bus.in_obj_out, bus.water_color};
    tests_run++;
    if (got !== 3'b110) begin
      tests_failed++;
      $display("FAIL scroll_next_new: got %b want 110", got);
    end
    send(4, 8, 0, 0);
    tests_run++;
    if (got !== 3'b111) begin
      tests_failed++;
      $display("FAIL scroll_x1_relx4: got %b want 111", got);
    end
    pulses(124);
    send(8, 8, 0, 0);
    tests_run++;
    if (got !== 3'b111) begin
      tests_failed++;
      $display("FAIL scroll_wrap: got %b want 111", got);
    end
    bus.scroll_en = 1'b0;
    pulses(4);
    send(4, 8, 0, 0);
    tests_run++;
    if (got !== 3'b110) begin
      tests_failed++;
      $display("FAIL scroll_disabled_hold: got %b want 110", got);
    end
    bus.scroll_en = 1'b1;
    bus.mode = 2'b10;
    pulses(4);
    bus.scroll_en = 1'b0;
    send(8, 4, 0, 0);
    tests_run++;
    if (got !== 3'b111) begin
      tests_failed++;
      $display("FAIL scroll_y_step_x_hold: got %b want 111", got);
    end
  endtask

  task automatic test_inflight_reset();
    @(negedge clk);
    pix(9, 4, 0, 0);
    @(negedge clk);
    pix(9, 4, 0, 0);
    @(negedge clk);
    bus.pix_valid_in = 1'b0;
    got = {bus.pix_valid_out, bus.in_obj_out, bus.water_color};
    tests_run++;
    if (got !== 3'b111) begin
      tests_failed++;
      $display("FAIL flush_pre: got %b want 111", got);
    end
    #1 rst_n = 1'b0;
    #1 got = {bus.pix_valid_out, bus.in_obj_out, bus.water_color};
    tests_run++;
    if (got !== 3'b000) begin
      tests_failed++;
      $display("FAIL flush_async_clear: got %b want 000", got);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      tests_run++;
      if (bus.pix_valid_out !== 1'b0) begin
        tests_failed++;
        $display("FAIL flush_no_stale_%0d: got %b want 0", i, bus.pix_valid_out);
      end
    end
    // Pattern and scroll were cleared: row 2 col 2 now reads 0.
    send(9, 8, 0, 0);
    tests_run++;
    if (got !== 3'b110) begin
      tests_failed++;
      $display("FAIL flush_after_release: got %b want 110", got);
    end
  endtask

  initial begin
    tests_run = 0;
    tests_failed = 0;
    test_reset();
    test_basic();
    test_pattern();
    test_edges();
    test_same_cycle_write();
    test_scroll();
    test_inflight_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
